// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule FSM states, word type, rcon and RotWord helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XOR   = 3'd1,
        ST_SUB   = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Round constant for round r; zero outside the AES-128 range 1..10.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // a0 a1 a2 a3 -> a1 a2 a3 a0, with a0 in the top byte.
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/sbox.sv
// Forward AES S-box, one byte in, one byte out.
// Latency: combinational.
// Backpressure: none; pure lookup.
module sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/inv_key_expansion.sv
// AES-128 inverse key expansion: round key r -> round key r-1, one serial S-box.
// Latency: 7 cycles start->done (2 cycles when round_num is out of range).
// Backpressure: start is only honoured while idle; requests during busy are dropped.
module inv_key_expansion
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] round_key_in,
    input  logic [3:0]   round_num,
    output logic [127:0] prev_key,
    output logic         busy,
    output logic         done,
    output logic         err
);

    state_t       state;
    logic [127:0] key_q;
    logic [3:0]   rn_q;
    logic [1:0]   cnt;
    word_t        temp;

    word_t        rot_p3;
    logic [1:0]   byte_sel;
    logic [7:0]   sb_in;
    logic [7:0]   sb_out;
    logic         rn_valid;

    // p3 already sits in prev_key[127:96] once XOR has run; walk its rotated bytes a0..a3.
    always_comb begin
        rot_p3   = rot_word(prev_key[127:96]);
        byte_sel = 2'd3 - cnt;
        sb_in    = rot_p3[{byte_sel, 3'b000} +: 8];
        rn_valid = (rn_q >= 4'd1) && (rn_q <= 4'd10);
    end

    sbox u_sbox (
        .din  (sb_in),
        .dout (sb_out)
    );

    // Control FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            key_q    <= '0;
            rn_q     <= '0;
            cnt      <= '0;
            temp     <= '0;
            prev_key <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        key_q <= round_key_in;
                        rn_q  <= round_num;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_XOR;
                    end
                end
                ST_XOR: begin
                    if (!rn_valid) begin
                        prev_key <= key_q;
                        err      <= 1'b1;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        prev_key[127:32] <= {key_q[127:96] ^ key_q[95:64],
                                             key_q[95:64]  ^ key_q[63:32],
                                             key_q[63:32]  ^ key_q[31:0]};
                        cnt   <= 2'd0;
                        state <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    // Bytes arrive a0 first, so shifting left leaves a0 in the top byte.
                    temp <= {temp[23:0], sb_out};
                    cnt  <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    prev_key[31:0] <= key_q[31:0] ^ temp ^ {rcon(rn_q), 24'h0};
                    done           <= 1'b1;
                    state          <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: directed requests checked every cycle against a GF(2^8) reference.
// Latency: checks done at start+7 (valid) or start+2 (invalid round).
// Backpressure: exercises start pulses during busy and reset mid-operation.
module tb_inv_key_expansion;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] round_key_in;
    logic [3:0]   round_num;
    logic [127:0] prev_key;
    logic         busy;
    logic         done;
    logic         err;

    inv_key_expansion dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .round_key_in (round_key_in),
        .round_num    (round_num),
        .prev_key     (prev_key),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (field arithmetic, no lookup table) ----------------
    logic [7:0] sbm [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= x;
            x = xt(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        d = d << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbm[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, t, s;
        logic [7:0]  rc = 8'h01;
        if (r < 1 || r > 10) return k;
        for (int i = 1; i < int'(r); i++) rc = xt(rc);
        {w3, w2, w1, w0} = k;
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        t  = {p3[23:0], p3[31:24]};
        s  = {sbm[t[31:24]], sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]]};
        p0 = w0 ^ s ^ {rc, 24'h0};
        return {p3, p2, p1, p0};
    endfunction

    // ---------------- expectation state shared with the compare process ----------------
    bit           pending   = 1'b0;
    int           start_cyc = 0;
    int           done_cyc  = 0;
    logic [127:0] exp_key   = '0;
    bit           exp_err   = 1'b0;
    logic [127:0] held_key  = '0;
    bit           held_err  = 1'b0;

    // Cycle-by-cycle check of busy/done timing, result on done, held outputs while idle.
    always @(negedge clk) begin
        if (!rst) begin
            bit exp_busy;
            bit exp_done;
            exp_busy = pending && (cyc > start_cyc) && (cyc <= done_cyc);
            exp_done = pending && (cyc == done_cyc);
            chk("busy", {127'h0, busy}, {127'h0, exp_busy});
            chk("done", {127'h0, done}, {127'h0, exp_done});
            if (exp_done) begin
                chk("prev_key_on_done", prev_key, exp_key);
                chk("err_on_done", {127'h0, err}, {127'h0, exp_err});
                held_key = exp_key;
                held_err = exp_err;
            end else if (!exp_busy) begin
                chk("prev_key_held", prev_key, held_key);
                chk("err_held", {127'h0, err}, {127'h0, held_err});
            end
        end
    end

    // One request; poke pulses start with junk in cycles 3 and 5 of the operation.
    task automatic run(input logic [127:0] k, input logic [3:0] r, input bit poke);
        @(posedge clk); #1;
        round_key_in = k;
        round_num    = r;
        start        = 1'b1;
        start_cyc    = cyc;
        exp_key      = model(k, r);
        exp_err      = (r < 1 || r > 10);
        done_cyc     = cyc + (exp_err ? 2 : 7);
        pending      = 1'b1;
        do begin
            @(posedge clk); #1;
            round_key_in = {$urandom, $urandom, $urandom, $urandom};
            round_num    = 4'($urandom);
            start        = poke && (cyc == start_cyc + 3 || cyc == start_cyc + 5);
        end while (cyc < done_cyc);
        start = 1'b0;
    endtask

    // Start an operation, then assert rst together with start in its cycle 4.
    task automatic run_reset(input logic [127:0] k, input logic [3:0] r);
        @(posedge clk); #1;
        round_key_in = k;
        round_num    = r;
        start        = 1'b1;
        start_cyc    = cyc;
        exp_key      = model(k, r);
        exp_err      = 1'b0;
        done_cyc     = cyc + 7;
        pending      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst      = 1'b1;
        start    = 1'b1;
        pending  = 1'b0;
        held_key = '0;
        held_err = 1'b0;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
    endtask

    logic [127:0] r1_key, r10_key, r9_key, cipher_key, k;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        r1_key     = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
        cipher_key = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
        r10_key    = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
        r9_key     = {32'h575c006e, 32'h28d12941, 32'h19fadc21, 32'hac7766f3};

        rst          = 1'b1;
        start        = 1'b0;
        round_key_in = '0;
        round_num    = '0;
        build_sbox();

        // Pin the reference model with literal values.
        chk("model_sbox_00", {120'h0, sbm[8'h00]}, {120'h0, 8'h63});
        chk("model_sbox_53", {120'h0, sbm[8'h53]}, {120'h0, 8'hed});
        chk("model_round1", model(r1_key, 4'd1), cipher_key);
        chk("model_round10", model(r10_key, 4'd10), r9_key);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // FIPS-197 vectors, back to back (second start lands in cycle 8).
        run(r1_key, 4'd1, 1'b0);
        run(r10_key, 4'd10, 1'b0);

        // Invalid round numbers, then a valid one clears err.
        run(r10_key, 4'd0, 1'b0);
        run(r1_key, 4'd11, 1'b0);
        run(r1_key, 4'd1, 1'b0);

        // Walk the whole schedule back from round 10.
        k = r10_key;
        for (int r = 10; r >= 1; r--) begin
            run(k, 4'(r), 1'b0);
            k = model(k, 4'(r));
        end
        chk("chain_cipher_key", k, cipher_key);
        chk("chain_dut_result", prev_key, cipher_key);

        // start while busy is ignored.
        run(r10_key, 4'd10, 1'b1);
        run(r1_key, 4'd15, 1'b1);

        // Reset mid-operation aborts, then a fresh request completes.
        run_reset(r10_key, 4'd10);
        run(r1_key, 4'd1, 1'b0);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_key_expansion.md
# inv_key_expansion

Computes AES-128 inverse key expansion: given round key r (1..10) and r, produces round key r−1. Sits in front of the decryption datapath so the last round key can be walked back to the cipher key without storing the whole schedule. Uses one forward S-box serially, four bytes over four cycles, so area matches the encrypt-side key expansion.

## Interface
- No parameters; AES-128 only.
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- round_key_in  in  128  round key r; word0 = [31:0], word3 = [127:96]; byte a0 of each word = [31:24]
- round_num  in  4  round index r of round_key_in; valid 1..10
- prev_key  out  128  round key r−1, same packing
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse, prev_key valid
- err  out  1  set with done when round_num invalid; held until next accepted start

## Operation
- Notation: k = latched round_key_in, words k0..k3; p = result words p0..p3.
- p3 = k3 ^ k2; p2 = k2 ^ k1; p1 = k1 ^ k0.
- p0 = k0 ^ SubWord(RotWord(p3)) ^ {rcon[r], 24'h0}; RotWord(a0 a1 a2 a3) = a1 a2 a3 a0.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- States: IDLE, XOR, SUB, FINAL, DONE.
  - IDLE: start=1 → latch round_key_in, round_num; clear err; go XOR. start=0 → stay.
  - XOR: if latched round_num ∉ 1..10 → prev_key ← k, err ← 1, go DONE. Else compute p1..p3 into prev_key[127:32]; byte counter ← 0; go SUB.
  - SUB: one S-box lookup per cycle on byte cnt of RotWord(p3); store into temp word; cnt 0..3; cnt=3 → FINAL.
  - FINAL: prev_key[31:0] ← k0 ^ temp ^ {rcon, 24'h0}; go DONE.
  - DONE: done=1; go IDLE.
- prev_key and err hold their values after DONE until the next accepted start overwrites them (prev_key[127:32] changes in XOR, [31:0] in FINAL).
- start while busy: ignored, not queued.
- Input changes after the start cycle have no effect (inputs latched).

## Timing
- Reset values: prev_key=0, busy=0, done=0, err=0, state IDLE, cnt 0.
- rst has priority over start in the same cycle; rst mid-operation aborts, IDLE on next cycle, all outputs zeroed.
- Valid request: start high in cycle 0 → busy high cycles 1–7, done high in cycle 7, start accepted again in cycle 8. Latency 7 cycles.
- Invalid round_num: done in cycle 2, err=1 from cycle 2.
- done never high two consecutive cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package aes_pkg: state enum type, rcon lookup function (4-bit index → 8-bit, 0 outside 1..10), RotWord function, 32-bit word type. Encrypt-side key expansion should import the same rcon function.
- One sub-module: sbox (combinational 8→8 forward AES S-box), single instance, also reusable by the encrypt datapath.

## Test plan
- FIPS-197 round 1: round_key_in={2a6c7605,23a33939,88542cb1,a0fafe17}, round_num=1 → done at cycle 7, prev_key={09cf4f3c,abf71588,28aed2a6,2b7e1516}, err=0.
- FIPS-197 round 10: round_key_in={b6630ca6,e13f0cc8,c9ee2589,d014f9a8}, round_num=10 → prev_key={575c006e,28d12941,19fadc21,ac7766f3}.
- Chain: feed prev_key back with round_num 10,9,…,1 starting from the round-10 key → final prev_key = cipher key {09cf4f3c,abf71588,28aed2a6,2b7e1516}.
- Invalid: round_num=0 then 11 → done at cycle 2, err=1, prev_key = round_key_in.
- start pulsed in cycles 3 and 5 of an active operation → ignored, exactly one done, result unchanged.
- rst asserted in cycle 4 with start → next cycle busy=0, done=0, prev_key=0; no done pulse; fresh start afterward completes normally.
